// File: rtl/pwm_decoder.sv
// pwm_decoder
//
// Measures an incoming PWM waveform and reports its period and its high time,
// both in clk cycles. A rising edge starts a measurement window; the next
// rising edge closes it, publishes the counts and opens the following window.
// If no rising edge arrives within MAX_PERIOD cycles the input is treated as
// a constant level (0 % or 100 % duty): timeout is raised and the synchronized
// level at that moment is captured.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   pwm_in     in   asynchronous PWM input (synchronized internally)
//   period     out  cycles between the last two rising edges
//   duty       out  high cycles within that period
//   valid      out  one-cycle strobe, period/duty updated this cycle
//   timeout    out  no rising edge within MAX_PERIOD cycles (sticky until the
//                   next valid measurement)
//   level      out  synchronized input level captured at timeout
//   dbg_state  out  current FSM state (ARM=0, WAIT_RISE=1, MEASURE=2)
//
// Handshake: valid is a plain strobe with no ready; period/duty are stable
// from one valid until the next and must be taken on the valid cycle if the
// consumer needs to observe every measurement.

module pwm_decoder #(
    parameter int PWM_INTERVAL = 1200,
    parameter int MAX_PERIOD   = 2 * PWM_INTERVAL,
    localparam int CW          = $clog2(MAX_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    output logic [CW-1:0] period,
    output logic [CW-1:0] duty,
    output logic          valid,
    output logic          timeout,
    output logic          level,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ARM       = 2'd0,
        WAIT_RISE = 2'd1,
        MEASURE   = 2'd2
    } state_e;

    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PERIOD);
    localparam logic [CW-1:0] ONE     = CW'(1);

    // Input path: s1/s2 synchronize, s3 delays s2 by one cycle for edge detect.
    logic s1_q, s2_q, s3_q;
    logic rise;

    state_e        state_q, state_d;
    logic [CW-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [CW-1:0] hi_cnt_q, hi_cnt_d;
    logic [CW-1:0] period_q, period_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          valid_q, valid_d;
    logic          timeout_q, timeout_d;
    logic          level_q, level_d;

    assign rise = s2_q & ~s3_q;

    always_comb begin
        state_d   = state_q;
        pwm_cnt_d = pwm_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        period_d  = period_q;
        duty_d    = duty_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        level_d   = level_q;

        case (state_q)
            // Only accept a rise that follows an observed low, so an input
            // that is already high is not mistaken for a fresh edge.
            ARM: begin
                if (!s2_q) begin
                    state_d = WAIT_RISE;
                end
            end

            // First edge only opens a window; no complete period exists yet.
            WAIT_RISE: begin
                if (rise) begin
                    state_d   = MEASURE;
                    pwm_cnt_d = ONE;
                    hi_cnt_d  = ONE;
                end
            end

            MEASURE: begin
                // A rise on the MAX_PERIOD cycle is still a legal period, so
                // it is tested before the timeout condition.
                if (rise) begin
                    period_d  = pwm_cnt_q;
                    duty_d    = hi_cnt_q;
                    valid_d   = 1'b1;
                    timeout_d = 1'b0;
                    pwm_cnt_d = ONE;
                    hi_cnt_d  = ONE;
                end else if (pwm_cnt_q == MAX_CNT) begin
                    timeout_d = 1'b1;
                    level_d   = s2_q;
                    state_d   = ARM;
                end else begin
                    pwm_cnt_d = pwm_cnt_q + ONE;
                    hi_cnt_d  = hi_cnt_q + {{(CW-1){1'b0}}, s2_q};
                end
            end

            default: begin
                state_d = ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            state_q   <= ARM;
            pwm_cnt_q <= '0;
            hi_cnt_q  <= '0;
            period_q  <= '0;
            duty_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            s1_q      <= pwm_in;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            state_q   <= state_d;
            pwm_cnt_q <= pwm_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            period_q  <= period_d;
            duty_q    <= duty_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            level_q   <= level_d;
        end
    end

    assign period    = period_q;
    assign duty      = duty_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign level     = level_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed testbench for pwm_decoder with the default parameters
// (PWM_INTERVAL=1200, MAX_PERIOD=2400, 12-bit counts). Inputs are driven and
// outputs sampled on the falling clock edge. A monitor records every valid
// strobe's period/duty pair into obs_q; scenario tasks compare against
// hand-computed values.

module tb_pwm_decoder;

    localparam int CW = 12;

    logic          clk;
    logic          rst;
    logic          pwm_in;
    logic [CW-1:0] period;
    logic [CW-1:0] duty;
    logic          valid;
    logic          timeout;
    logic          level;
    logic [1:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*CW-1:0] obs_q[$];

    pwm_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .period    (period),
        .duty      (duty),
        .valid     (valid),
        .timeout   (timeout),
        .level     (level),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one entry per valid cycle.
    always @(negedge clk) begin
        if (valid === 1'b1) obs_q.push_back({period, duty});
    end

    // Driver: set pwm_in at the current falling edge and hold for n cycles.
    task automatic hold(input logic lvl, input int n);
        pwm_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset(input int n);
        rst = 1'b1;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        pwm_in = 1'b0;
        @(negedge clk);
        pulse_reset(3);
        if ({period, duty} !== '0) begin
            errors++; $display("FAIL reset_counts period=%0d duty=%0d want 0/0", period, duty);
        end
        checks++;
        if ({valid, timeout, level} !== 3'b000) begin
            errors++; $display("FAIL reset_flags valid/timeout/level=%b want 000", {valid, timeout, level});
        end
        checks++;
        // Released at this falling edge; state is still the reset state.
        if (dbg_state !== 2'd0) begin
            errors++; $display("FAIL reset_state state=%0d want 0", dbg_state);
        end
        checks++;
        hold(1'b0, 20);
    endtask

    task automatic test_steady;
        logic [2*CW-1:0] e;
        obs_q.delete();
        // Five rising edges -> four complete periods.
        for (int p = 0; p < 5; p++) begin
            hold(1'b1, 300);
            hold(1'b0, 900);
        end
        if (obs_q.size() !== 4) begin
            errors++; $display("FAIL steady_count got=%0d want 4", obs_q.size());
        end
        checks++;
        while (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            if (e !== {12'd1200, 12'd300}) begin
                errors++; $display("FAIL steady_meas period=%0d duty=%0d want 1200/300", e[2*CW-1:CW], e[CW-1:0]);
            end
            checks++;
        end
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL steady_timeout got=%b want 0", timeout);
        end
        checks++;
    endtask

    task automatic test_switch;
        logic [2*CW-1:0] e;
        obs_q.delete();
        for (int p = 0; p < 4; p++) begin
            hold(1'b1, 900);
            hold(1'b0, 300);
        end
        if (obs_q.size() !== 4) begin
            errors++; $display("FAIL switch_count got=%0d want 4", obs_q.size());
        end
        checks++;
        // First edge of the new stream closes the last 300-high period.
        for (int i = 0; i < 4 && obs_q.size() > 0; i++) begin
            e = obs_q.pop_front();
            if (e !== {12'd1200, (i == 0) ? 12'd300 : 12'd900}) begin
                errors++; $display("FAIL switch_meas%0d period=%0d duty=%0d want 1200/%0d", i, e[2*CW-1:CW], e[CW-1:0], (i == 0) ? 300 : 900);
            end
            checks++;
        end
    endtask

    task automatic test_timeout_low;
        hold(1'b1, 300);
        hold(1'b0, 900);
        hold(1'b1, 300);   // this edge publishes 1200/300
        obs_q.delete();
        // Edge seen by the FSM on the 3rd rising clock after the drive;
        // timeout lands 2400 cycles later, visible at falling edge 2403.
        hold(1'b0, 2102);
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL tmo_early got=%b want 0", timeout);
        end
        checks++;
        hold(1'b0, 1);
        if ({timeout, level} !== 2'b10) begin
            errors++; $display("FAIL tmo_low timeout/level=%b want 10", {timeout, level});
        end
        checks++;
        if ({period, duty} !== {12'd1200, 12'd300}) begin
            errors++; $display("FAIL tmo_hold period=%0d duty=%0d want 1200/300", period, duty);
        end
        checks++;
        hold(1'b0, 200);
        if (obs_q.size() !== 0 || timeout !== 1'b1) begin
            errors++; $display("FAIL tmo_quiet valids=%0d timeout=%b want 0/1", obs_q.size(), timeout);
        end
        checks++;
    endtask

    task automatic test_high_from_reset;
        logic [2*CW-1:0] e;
        pwm_in = 1'b1;
        pulse_reset(2);
        obs_q.delete();
        hold(1'b1, 3000);
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL hi_novalid got=%0d want 0", obs_q.size());
        end
        checks++;
        hold(1'b0, 10);
        hold(1'b1, 100);
        hold(1'b0, 100);
        hold(1'b1, 5);     // closes a 200-cycle period with 100 high
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL hi_resume_count got=%0d want 1", obs_q.size());
        end
        checks++;
        if (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            if (e !== {12'd200, 12'd100}) begin
                errors++; $display("FAIL hi_resume_meas period=%0d duty=%0d want 200/100", e[2*CW-1:CW], e[CW-1:0]);
            end
            checks++;
        end
        if (timeout !== 1'b0) begin
            errors++; $display("FAIL hi_resume_tmo got=%b want 0", timeout);
        end
        checks++;
        hold(1'b1, 2995);
        if ({timeout, level} !== 2'b11) begin
            errors++; $display("FAIL hi_stuck timeout/level=%b want 11", {timeout, level});
        end
        checks++;
        if ({period, duty} !== {12'd200, 12'd100} || obs_q.size() !== 0) begin
            errors++; $display("FAIL hi_stuck_hold period=%0d duty=%0d valids=%0d want 200/100/0", period, duty, obs_q.size());
        end
        checks++;
    endtask

    task automatic test_max_period;
        logic [2*CW-1:0] e;
        hold(1'b0, 10);
        hold(1'b1, 100);
        hold(1'b0, 2300);
        obs_q.delete();
        hold(1'b1, 100);   // rise exactly at count 2400
        hold(1'b0, 2301);
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL max_count got=%0d want 1", obs_q.size());
        end
        checks++;
        if (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            if (e !== {12'd2400, 12'd100}) begin
                errors++; $display("FAIL max_meas period=%0d duty=%0d want 2400/100", e[2*CW-1:CW], e[CW-1:0]);
            end
            checks++;
        end
        // 2401-cycle period: timeout fires one cycle before the next edge.
        hold(1'b1, 100);
        if ({timeout, level} !== 2'b10 || obs_q.size() !== 0) begin
            errors++; $display("FAIL over_max timeout/level=%b valids=%0d want 10/0", {timeout, level}, obs_q.size());
        end
        checks++;
        if ({period, duty} !== {12'd2400, 12'd100}) begin
            errors++; $display("FAIL over_max_hold period=%0d duty=%0d want 2400/100", period, duty);
        end
        checks++;
    endtask

    task automatic test_reset_mid;
        logic [2*CW-1:0] e;
        hold(1'b0, 900);
        hold(1'b1, 300);
        hold(1'b0, 900);
        hold(1'b1, 300);   // publishes 1200/300
        hold(1'b0, 300);
        pulse_reset(1);
        obs_q.delete();
        if ({period, duty, valid, timeout, level} !== '0 || dbg_state !== 2'd0) begin
            errors++; $display("FAIL mid_reset period=%0d duty=%0d v/t/l=%b state=%0d want all 0", period, duty, {valid, timeout, level}, dbg_state);
        end
        checks++;
        hold(1'b0, 300);
        hold(1'b1, 300);
        hold(1'b0, 900);
        if (obs_q.size() !== 0) begin
            errors++; $display("FAIL mid_first_edge valids=%0d want 0", obs_q.size());
        end
        checks++;
        hold(1'b1, 2);
        if (valid !== 1'b0) begin
            errors++; $display("FAIL latency_early valid=%b want 0", valid);
        end
        checks++;
        hold(1'b1, 1);
        if (valid !== 1'b1) begin
            errors++; $display("FAIL latency valid=%b want 1", valid);
        end
        checks++;
        hold(1'b1, 1);
        if (valid !== 1'b0) begin
            errors++; $display("FAIL valid_width valid=%b want 0", valid);
        end
        checks++;
        hold(1'b1, 10);
        if (obs_q.size() !== 1) begin
            errors++; $display("FAIL mid_second_edge valids=%0d want 1", obs_q.size());
        end
        checks++;
        if (obs_q.size() > 0) begin
            e = obs_q.pop_front();
            if (e !== {12'd1200, 12'd300}) begin
                errors++; $display("FAIL mid_meas period=%0d duty=%0d want 1200/300", e[2*CW-1:CW], e[CW-1:0]);
            end
            checks++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        test_reset();
        test_steady();
        test_switch();
        test_timeout_low();
        test_high_from_reset();
        test_max_period();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
